// File: rtl/increment_register.sv
// rtl/increment_register.sv - bank of three read-only event counters for performance statistics
//
// Purpose:
//   Three independent WIDTH-bit up-counters. Each advances by one on every
//   rising clock edge that samples its execute strobe high. Counters wrap
//   modulo 2^WIDTH; there is no saturation, overflow flag, load or write path.
//
// Ports:
//   clk              in   1      system clock, counting on the rising edge
//   reset            in   1      asynchronous active-low clear of all counters
//   Instruc_Count_Ex in   1      instruction-executed strobe
//   MEM_Acc_Ex       in   1      memory-access strobe
//   MEM_Correct_Ex   in   1      memory-correction strobe
//   Instruc_Reg      out  WIDTH  instruction count
//   MEM_Acc_Reg      out  WIDTH  memory access count
//   MEM_Correct_Reg  out  WIDTH  memory correction count

module increment_register #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Instruc_Count_Ex,
  input  logic             MEM_Acc_Ex,
  input  logic             MEM_Correct_Ex,
  output logic [WIDTH-1:0] Instruc_Reg,
  output logic [WIDTH-1:0] MEM_Acc_Reg,
  output logic [WIDTH-1:0] MEM_Correct_Reg
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // The counters are the output registers themselves, so there is no
  // combinational path from a strobe to an output. Each counter is kept in
  // its own block to make the absence of any interaction obvious.

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Instruc_Reg <= '0;
    end else if (Instruc_Count_Ex) begin
      Instruc_Reg <= Instruc_Reg + ONE;  // wraps naturally at 2^WIDTH
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      MEM_Acc_Reg <= '0;
    end else if (MEM_Acc_Ex) begin
      MEM_Acc_Reg <= MEM_Acc_Reg + ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      MEM_Correct_Reg <= '0;
    end else if (MEM_Correct_Ex) begin
      MEM_Correct_Reg <= MEM_Correct_Reg + ONE;
    end
  end

endmodule

// File: tb/tb_increment_register.sv
// tb/tb_increment_register.sv - scoreboard bench for increment_register

module tb_increment_register;

  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         Instruc_Count_Ex;
  logic         MEM_Acc_Ex;
  logic         MEM_Correct_Ex;
  logic [W-1:0] Instruc_Reg;
  logic [W-1:0] MEM_Acc_Reg;
  logic [W-1:0] MEM_Correct_Reg;

  always #5 clk = ~clk;

  increment_register #(.WIDTH(W)) dut (
    .clk              (clk),
    .reset            (reset),
    .Instruc_Count_Ex (Instruc_Count_Ex),
    .MEM_Acc_Ex       (MEM_Acc_Ex),
    .MEM_Correct_Ex   (MEM_Correct_Ex),
    .Instruc_Reg      (Instruc_Reg),
    .MEM_Acc_Reg      (MEM_Acc_Reg),
    .MEM_Correct_Reg  (MEM_Correct_Reg)
  );

  typedef struct {
    logic [W-1:0] i;
    logic [W-1:0] a;
    logic [W-1:0] c;
    string        tag;
  } exp_t;

  exp_t q[$];
  event sample_ev;
  int   vectors = 0;
  int   miscompares = 0;

  // reference counters
  int mi = 0;
  int ma = 0;
  int mc = 0;

  task automatic push(input string tag);
    exp_t e;
    e.i   = mi[W-1:0];
    e.a   = ma[W-1:0];
    e.c   = mc[W-1:0];
    e.tag = tag;
    q.push_back(e);
  endtask

  // drive strobes, let one rising edge pass, record the expected state
  task automatic edge_check(input logic si, input logic sa, input logic sc, input string tag);
    Instruc_Count_Ex = si;
    MEM_Acc_Ex       = sa;
    MEM_Correct_Ex   = sc;
    @(posedge clk);
    if (reset) begin
      if (si) mi = (mi + 1) & MASK;
      if (sa) ma = (ma + 1) & MASK;
      if (sc) mc = (mc + 1) & MASK;
    end else begin
      mi = 0; ma = 0; mc = 0;
    end
    #1 push(tag);
  endtask

  // assert reset mid-low-phase and sample immediately, well before the next edge
  task automatic async_clear(input string tag);
    @(negedge clk);
    #1 reset = 1'b0;
    mi = 0; ma = 0; mc = 0;
    #1 push(tag);
    -> sample_ev;
  endtask

  // monitor: drains the scoreboard whenever outputs are sampled
  initial begin
    forever begin
      @(negedge clk or sample_ev);
      while (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        vectors++;
        if (Instruc_Reg !== e.i || MEM_Acc_Reg !== e.a || MEM_Correct_Reg !== e.c) begin
          miscompares++;
          $display("FAIL %s: got instr=%h acc=%h corr=%h, expected instr=%h acc=%h corr=%h at %0t",
                   e.tag, Instruc_Reg, MEM_Acc_Reg, MEM_Correct_Reg, e.i, e.a, e.c, $time);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected completion before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset            = 1'b0;
    Instruc_Count_Ex = 1'b1;
    MEM_Acc_Ex       = 1'b1;
    MEM_Correct_Ex   = 1'b1;
    #1 push("reset_initial");
    -> sample_ev;

    // reset held with every strobe active
    for (int k = 0; k < 5; k++) edge_check(1'b1, 1'b1, 1'b1, "reset_hold");

    @(negedge clk);
    #1 reset = 1'b1;

    // single strobe: 1, 2, 3, 4
    for (int k = 0; k < 4; k++) edge_check(1'b1, 1'b0, 0, "single_instr");

    // asynchronous clear between edges
    async_clear("async_clear");
    @(negedge clk);
    #1 reset = 1'b1;

    // simultaneous strobes then memory-access strobe dropped: ends at 5, 3, 5
    for (int k = 0; k < 3; k++) edge_check(1'b1, 1'b1, 1'b1, "simul_all");
    for (int k = 0; k < 2; k++) edge_check(1'b1, 1'b0, 1'b1, "simul_no_acc");

    // hold
    for (int k = 0; k < 10; k++) edge_check(1'b0, 1'b0, 1'b0, "hold");

    // correction counter 5 -> 0xE, then 0xF and wrap to 0
    for (int k = 0; k < 9; k++) edge_check(1'b0, 1'b0, 1'b1, "wrap_ramp");
    edge_check(1'b0, 1'b0, 1'b1, "wrap_max");
    edge_check(1'b0, 1'b0, 1'b1, "wrap_zero");

    // make all counters nonzero, then a short reset pulse with strobes high
    edge_check(1'b1, 1'b1, 1'b1, "pre_pulse");
    async_clear("midop_pulse");
    #2 reset = 1'b1;
    edge_check(1'b1, 1'b1, 1'b1, "after_pulse");

    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/increment_register.md
# increment_register

Bank of three read-only 20-bit event counters for the CPU's performance/statistics block: instruction count, memory access count and memory correction count. Each counter advances by one on every rising clock edge on which its execute strobe is high. The control unit drives the strobes. Software and debug logic only read the outputs; there is no load or write path.

## Interface
- `WIDTH`, default 20: counter width in bits. All three counters share it.

- `clk`  input  1  system clock; all counting happens on the rising edge.
- `reset`  input  1  asynchronous, active-low reset. `reset` = 0 clears all counters immediately.
- `Instruc_Count_Ex`  input  1  instruction-executed strobe. Increments `Instruc_Reg`.
- `MEM_Acc_Ex`  input  1  memory-access strobe. Increments `MEM_Acc_Reg`.
- `MEM_Correct_Ex`  input  1  memory-correction strobe. Increments `MEM_Correct_Reg`.
- `Instruc_Reg`  output  WIDTH  instruction count.
- `MEM_Acc_Reg`  output  WIDTH  memory access count.
- `MEM_Correct_Reg`  output  WIDTH  memory correction count.

## Operation
- Three independent counters. Each is a WIDTH-bit register driven directly to its output port.
- While `reset` = 0:
  - all three counters are forced to 0, regardless of clock or strobes;
  - strobes are ignored.
- While `reset` = 1, on each rising edge of `clk`:
  - if `Instruc_Count_Ex` = 1: `Instruc_Reg` <= `Instruc_Reg` + 1;
  - if `MEM_Acc_Ex` = 1: `MEM_Acc_Reg` <= `MEM_Acc_Reg` + 1;
  - if `MEM_Correct_Ex` = 1: `MEM_Correct_Reg` <= `MEM_Correct_Reg` + 1;
  - a counter whose strobe is 0 holds its value.
- Strobes are level-sensitive. A strobe held high for N rising edges adds exactly N.
- Any combination of strobes may be active in the same cycle. Each counter updates independently, with no priority or interaction.
- Arithmetic is unsigned modulo 2^WIDTH.
  - The maximum value is 2^WIDTH - 1 (0xFFFFF for WIDTH = 20).
  - An increment from the maximum wraps to 0.
  - There is no saturation and no overflow flag.
- There are no other inputs that modify the counters.

## Timing
- Reset assertion is asynchronous: outputs go to 0 without waiting for a clock edge.
- Reset deassertion: the first increment can occur on the first rising edge after `reset` goes high.
  - Integrators must release reset away from the rising edge (synchronised release is the integrator's responsibility).
- Increment latency: the output reflects the increment immediately after the rising edge that sampled the strobe high. This is one cycle of latency and there is no combinational path from strobe to output.
- Strobes must be stable around the rising edge (setup/hold). There is no handshake or acknowledge.
- Reset asserted mid-count clears all counters at once. Counting resumes from 0 after release.

## Test plan
- Reset: hold `reset` = 0 for 5 cycles with all strobes = 1.
  - Required: all outputs = 0 throughout.
  - Assert `reset` = 0 between clock edges: outputs clear before the next edge.
- Single strobe: release reset, then hold `Instruc_Count_Ex` = 1 and the other strobes = 0 for 4 edges.
  - Required: `Instruc_Reg` = 1, 2, 3, 4 after successive edges.
  - Required: the other two outputs stay 0.
- Simultaneous strobes: all three strobes = 1 for 3 edges, then `MEM_Acc_Ex` = 0 for 2 more edges.
  - Required: `Instruc_Reg` = 5, `MEM_Acc_Reg` = 3, `MEM_Correct_Reg` = 5.
- Hold: all strobes = 0 for 10 edges.
  - Required: all outputs unchanged.
- Wrap-around: count `MEM_Correct_Reg` up to 0xFFFFE (by a long run, or with WIDTH reduced to 4 so the target is 0xE), then strobe 2 more edges.
  - Required: 0xFFFFF, then 0x00000 (0xF, then 0x0 for WIDTH = 4).
- Reset mid-operation: with all counters nonzero and strobes high, pulse `reset` = 0 for half a cycle.
  - Required: all outputs 0 during the pulse.
  - Required: outputs = 1 after the first rising edge following release.
